// File: rtl/ahbl_obi_bridge.sv
// OBI request/grant/rvalid to AHB-Lite master bridge. Address phase is driven
// combinationally from the OBI request; the data phase is tracked by a small
// FSM that holds write data, returns read data and handles two-cycle ERROR.
module ahbl_obi_bridge #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter bit          READ_ONLY  = 1'b0,
  parameter logic [3:0]  HPROT_VAL  = 4'b0011
) (
  input  logic                    clk_cpu,
  input  logic                    rstn_cpu,
  input  logic                    req_i,
  output logic                    gnt_o,
  output logic                    rvalid_o,
  output logic                    err_o,
  input  logic                    we_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic [ADDR_WIDTH-1:0]   err_addr_o,
  output logic [ADDR_WIDTH-1:0]   haddr_o,
  output logic [2:0]              hburst_o,
  output logic                    hmastlock_o,
  output logic [3:0]              hprot_o,
  output logic [2:0]              hsize_o,
  output logic [1:0]              htrans_o,
  output logic                    hwrite_o,
  output logic [DATA_WIDTH-1:0]   hwdata_o,
  input  logic [DATA_WIDTH-1:0]   hrdata_i,
  input  logic                    hready_i,
  input  logic                    hresp_i
);

  localparam int unsigned LaneBits = $clog2(DATA_WIDTH / 8);

  typedef enum logic [1:0] {StIdle, StData, StErr} state_e;

  state_e                  r_state, w_state_d;
  logic                    r_dp_we;
  logic [DATA_WIDTH-1:0]   r_dp_wdata;
  logic [ADDR_WIDTH-1:0]   r_dp_addr;
  logic [ADDR_WIDTH-1:0]   r_err_addr;
  logic                    r_ro_pend;

  logic                    w_ro_wr;
  logic                    w_bus_ok;
  logic                    w_gnt;
  logic                    w_bus_acc;
  logic                    w_ro_acc;
  logic [7:0]              w_be8;
  logic [LaneBits-1:0]     w_low;
  logic [2:0]              w_hsize;

  // A write on a read-only channel never reaches the bus; it is answered locally.
  assign w_ro_wr   = READ_ONLY & we_i;
  // No new address phase during an error response or a pending local error.
  assign w_bus_ok  = ~hresp_i & ~r_ro_pend & (r_state != StErr);
  assign w_gnt     = req_i & hready_i & w_bus_ok & (~w_ro_wr | (r_state == StIdle));
  assign w_bus_acc = w_gnt & ~w_ro_wr;
  assign w_ro_acc  = w_gnt & w_ro_wr;

  assign gnt_o       = w_gnt;
  assign htrans_o    = (req_i & w_bus_ok & ~w_ro_wr) ? 2'b10 : 2'b00;
  assign hwrite_o    = we_i & ~READ_ONLY;
  assign hburst_o    = 3'b000;
  assign hmastlock_o = 1'b0;
  assign hprot_o     = HPROT_VAL;
  assign hsize_o     = w_hsize;
  assign haddr_o     = {addr_i[ADDR_WIDTH-1:LaneBits], w_low};
  assign err_addr_o  = r_err_addr;
  // Registered write data stays on the bus for the whole data phase.
  assign hwdata_o    = ((r_state != StIdle) && r_dp_we) ? r_dp_wdata : '0;

  // Derive transfer size and low address bits from the byte-enable pattern.
  always_comb begin
    w_be8   = 8'(be_i);
    w_low   = '0;
    w_hsize = (DATA_WIDTH == 64) ? 3'd3 : 3'd2;
    case (w_be8)
      8'h01: begin w_hsize = 3'd0; w_low = LaneBits'(0); end
      8'h02: begin w_hsize = 3'd0; w_low = LaneBits'(1); end
      8'h04: begin w_hsize = 3'd0; w_low = LaneBits'(2); end
      8'h08: begin w_hsize = 3'd0; w_low = LaneBits'(3); end
      8'h10: begin w_hsize = 3'd0; w_low = LaneBits'(4); end
      8'h20: begin w_hsize = 3'd0; w_low = LaneBits'(5); end
      8'h40: begin w_hsize = 3'd0; w_low = LaneBits'(6); end
      8'h80: begin w_hsize = 3'd0; w_low = LaneBits'(7); end
      8'h03: begin w_hsize = 3'd1; w_low = LaneBits'(0); end
      8'h0C: begin w_hsize = 3'd1; w_low = LaneBits'(2); end
      8'h30: begin w_hsize = 3'd1; w_low = LaneBits'(4); end
      8'hC0: begin w_hsize = 3'd1; w_low = LaneBits'(6); end
      8'h0F: begin w_hsize = 3'd2; w_low = LaneBits'(0); end
      8'hF0: begin w_hsize = 3'd2; w_low = LaneBits'(4); end
      8'hFF: begin w_hsize = 3'd3; w_low = LaneBits'(0); end
      default: ;
    endcase
  end

  // Next-state and OBI response generation for the data phase.
  always_comb begin
    w_state_d = r_state;
    rvalid_o  = 1'b0;
    err_o     = 1'b0;
    rdata_o   = '0;
    if (r_ro_pend) begin
      rvalid_o = 1'b1;
      err_o    = 1'b1;
    end
    case (r_state)
      StIdle: begin
        if (w_bus_acc) w_state_d = StData;
      end
      StData: begin
        if (hresp_i) begin
          // ERROR with HREADY high already is the second cycle; finish here.
          if (hready_i) begin
            rvalid_o  = 1'b1;
            err_o     = 1'b1;
            w_state_d = StIdle;
          end else begin
            w_state_d = StErr;
          end
        end else if (hready_i) begin
          rvalid_o  = 1'b1;
          rdata_o   = r_dp_we ? '0 : hrdata_i;
          w_state_d = w_bus_acc ? StData : StIdle;
        end
      end
      StErr: begin
        if (hresp_i && hready_i) begin
          rvalid_o  = 1'b1;
          err_o     = 1'b1;
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // State, data-phase capture and error-address registers.
  always_ff @(posedge clk_cpu or negedge rstn_cpu) begin
    if (!rstn_cpu) begin
      r_state    <= StIdle;
      r_dp_we    <= 1'b0;
      r_dp_wdata <= '0;
      r_dp_addr  <= '0;
      r_err_addr <= '0;
      r_ro_pend  <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_ro_pend <= w_ro_acc;
      if (w_bus_acc) begin
        r_dp_we    <= we_i & ~READ_ONLY;
        r_dp_wdata <= wdata_i;
        r_dp_addr  <= addr_i;
      end
      // Capture on the first ERROR cycle so the address is valid with err_o.
      if (w_ro_acc) begin
        r_err_addr <= addr_i;
      end else if ((r_state == StData) && hresp_i) begin
        r_err_addr <= r_dp_addr;
      end
    end
  end

endmodule

// File: tb/tb_ahbl_obi_bridge.sv
// Directed bench for ahbl_obi_bridge: one read/write instance and one
// READ_ONLY instance share the stimulus; inputs change on the falling edge
// and outputs are sampled 1ns later.
module tb_ahbl_obi_bridge;

  logic        clk_cpu = 1'b0;
  logic        rstn_cpu;
  logic        req;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] hrdata;
  logic        hready;
  logic        hresp;

  logic        gnt, rvalid, err, hwrite, hmastlock;
  logic [31:0] rdata, err_addr, haddr, hwdata;
  logic [2:0]  hburst, hsize;
  logic [3:0]  hprot;
  logic [1:0]  htrans;

  logic        ro_gnt, ro_rvalid, ro_err, ro_hwrite, ro_hmastlock;
  logic [31:0] ro_rdata, ro_err_addr, ro_haddr, ro_hwdata;
  logic [2:0]  ro_hburst, ro_hsize;
  logic [3:0]  ro_hprot;
  logic [1:0]  ro_htrans;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_cpu = ~clk_cpu;

  ahbl_obi_bridge #(.READ_ONLY(1'b0)) dut (
    .clk_cpu(clk_cpu), .rstn_cpu(rstn_cpu), .req_i(req), .gnt_o(gnt),
    .rvalid_o(rvalid), .err_o(err), .we_i(we), .be_i(be), .addr_i(addr),
    .wdata_i(wdata), .rdata_o(rdata), .err_addr_o(err_addr), .haddr_o(haddr),
    .hburst_o(hburst), .hmastlock_o(hmastlock), .hprot_o(hprot), .hsize_o(hsize),
    .htrans_o(htrans), .hwrite_o(hwrite), .hwdata_o(hwdata), .hrdata_i(hrdata),
    .hready_i(hready), .hresp_i(hresp)
  );

  ahbl_obi_bridge #(.READ_ONLY(1'b1)) dut_ro (
    .clk_cpu(clk_cpu), .rstn_cpu(rstn_cpu), .req_i(req), .gnt_o(ro_gnt),
    .rvalid_o(ro_rvalid), .err_o(ro_err), .we_i(we), .be_i(be), .addr_i(addr),
    .wdata_i(wdata), .rdata_o(ro_rdata), .err_addr_o(ro_err_addr), .haddr_o(ro_haddr),
    .hburst_o(ro_hburst), .hmastlock_o(ro_hmastlock), .hprot_o(ro_hprot),
    .hsize_o(ro_hsize), .htrans_o(ro_htrans), .hwrite_o(ro_hwrite), .hwdata_o(ro_hwdata),
    .hrdata_i(hrdata), .hready_i(hready), .hresp_i(hresp)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge; caller then drives inputs and waits #1.
  task automatic next_cycle();
    @(negedge clk_cpu);
  endtask

  initial begin
    rstn_cpu = 1'b0; req = 1'b0; we = 1'b0; be = 4'hF; addr = '0; wdata = '0;
    hrdata = '0; hready = 1'b1; hresp = 1'b0;
    #1;
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_htrans", 32'(htrans), 32'd0);
    check("rst_hwdata", hwdata, 32'd0);
    check("rst_err_addr", err_addr, 32'd0);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("const_hprot", 32'(hprot), 32'h3);
    check("const_hburst", 32'(hburst), 32'd0);
    check("const_hmastlock", 32'(hmastlock), 32'd0);
    next_cycle();
    rstn_cpu = 1'b1;

    // Zero-wait back-to-back reads.
    next_cycle(); req = 1'b1; we = 1'b0; be = 4'hF; addr = 32'h100; #1;
    check("rd0_gnt", 32'(gnt), 32'd1);
    check("rd0_htrans", 32'(htrans), 32'h2);
    check("rd0_haddr", haddr, 32'h100);
    check("rd0_hsize", 32'(hsize), 32'd2);
    check("rd0_rvalid", 32'(rvalid), 32'd0);
    next_cycle(); addr = 32'h104; hrdata = 32'hA; #1;
    check("rd1_htrans", 32'(htrans), 32'h2);
    check("rd1_rvalid", 32'(rvalid), 32'd1);
    check("rd1_rdata", rdata, 32'hA);
    next_cycle(); addr = 32'h108; hrdata = 32'hB; #1;
    check("rd2_htrans", 32'(htrans), 32'h2);
    check("rd2_rvalid", 32'(rvalid), 32'd1);
    check("rd2_rdata", rdata, 32'hB);
    next_cycle(); req = 1'b0; hrdata = 32'hC; #1;
    check("rd3_htrans", 32'(htrans), 32'h0);
    check("rd3_rvalid", 32'(rvalid), 32'd1);
    check("rd3_rdata", rdata, 32'hC);
    next_cycle(); #1;
    check("rd4_rvalid", 32'(rvalid), 32'd0);

    // Word write with two wait states; a following read stays ungranted.
    next_cycle(); req = 1'b1; we = 1'b1; be = 4'hF; addr = 32'h110; wdata = 32'hDEADBEEF; #1;
    check("wr_gnt", 32'(gnt), 32'd1);
    check("wr_hsize", 32'(hsize), 32'd2);
    check("wr_hwrite", 32'(hwrite), 32'd1);
    check("wr_hwdata_addr_phase", hwdata, 32'd0);
    next_cycle(); we = 1'b0; addr = 32'h114; wdata = 32'h0; hready = 1'b0; #1;
    check("wr_w1_hwdata", hwdata, 32'hDEADBEEF);
    check("wr_w1_rvalid", 32'(rvalid), 32'd0);
    check("wr_w1_gnt", 32'(gnt), 32'd0);
    next_cycle(); #1;
    check("wr_w2_hwdata", hwdata, 32'hDEADBEEF);
    check("wr_w2_rvalid", 32'(rvalid), 32'd0);
    check("wr_w2_gnt", 32'(gnt), 32'd0);
    next_cycle(); hready = 1'b1; #1;
    check("wr_done_hwdata", hwdata, 32'hDEADBEEF);
    check("wr_done_rvalid", 32'(rvalid), 32'd1);
    check("wr_done_err", 32'(err), 32'd0);
    check("wr_done_rdata", rdata, 32'd0);
    check("wr_next_gnt", 32'(gnt), 32'd1);
    next_cycle(); req = 1'b0; hrdata = 32'h55; #1;
    check("wr_rd_rvalid", 32'(rvalid), 32'd1);
    check("wr_rd_rdata", rdata, 32'h55);
    check("wr_rd_hwdata", hwdata, 32'd0);
    next_cycle(); #1;
    check("wr_idle_rvalid", 32'(rvalid), 32'd0);

    // Byte-lane derived size and address (combinational, no request).
    addr = 32'h200; be = 4'b0100; #1;
    check("lane_b2_haddr", haddr, 32'h202);
    check("lane_b2_hsize", 32'(hsize), 32'd0);
    be = 4'b1100; #1;
    check("lane_h1_haddr", haddr, 32'h202);
    check("lane_h1_hsize", 32'(hsize), 32'd1);
    be = 4'b0101; #1;
    check("lane_sparse_haddr", haddr, 32'h200);
    check("lane_sparse_hsize", 32'(hsize), 32'd2);
    addr = 32'h201; be = 4'b1000; #1;
    check("lane_b3_haddr", haddr, 32'h203);
    check("lane_b3_hsize", 32'(hsize), 32'd0);
    addr = 32'h203; be = 4'b0110; #1;
    check("lane_misal_haddr", haddr, 32'h200);
    check("lane_misal_hsize", 32'(hsize), 32'd2);
    be = 4'b0000; #1;
    check("lane_zero_hsize", 32'(hsize), 32'd2);

    // Two-cycle ERROR with the next read held pending.
    next_cycle(); req = 1'b1; we = 1'b0; be = 4'hF; addr = 32'h300; #1;
    check("er_gnt", 32'(gnt), 32'd1);
    next_cycle(); addr = 32'h304; hready = 1'b0; hresp = 1'b1; #1;
    check("er1_htrans", 32'(htrans), 32'h0);
    check("er1_gnt", 32'(gnt), 32'd0);
    check("er1_rvalid", 32'(rvalid), 32'd0);
    next_cycle(); hready = 1'b1; #1;
    check("er2_htrans", 32'(htrans), 32'h0);
    check("er2_gnt", 32'(gnt), 32'd0);
    check("er2_rvalid", 32'(rvalid), 32'd1);
    check("er2_err", 32'(err), 32'd1);
    check("er2_err_addr", err_addr, 32'h300);
    next_cycle(); hresp = 1'b0; #1;
    check("er_next_gnt", 32'(gnt), 32'd1);
    check("er_next_htrans", 32'(htrans), 32'h2);
    check("er_next_rvalid", 32'(rvalid), 32'd0);
    next_cycle(); req = 1'b0; hrdata = 32'h77; #1;
    check("er_next_rd_rvalid", 32'(rvalid), 32'd1);
    check("er_next_rd_err", 32'(err), 32'd0);
    check("er_next_rd_rdata", rdata, 32'h77);
    next_cycle(); #1;
    check("er_hold_err_addr", err_addr, 32'h300);
    next_cycle(); #1;

    // READ_ONLY channel receiving a write.
    next_cycle(); req = 1'b1; we = 1'b1; be = 4'hF; addr = 32'h40; wdata = 32'h99; #1;
    check("ro_gnt", 32'(ro_gnt), 32'd1);
    check("ro_htrans", 32'(ro_htrans), 32'h0);
    check("ro_hwrite", 32'(ro_hwrite), 32'd0);
    check("ro_rvalid_early", 32'(ro_rvalid), 32'd0);
    next_cycle(); addr = 32'h44; #1;
    check("ro_rsp_rvalid", 32'(ro_rvalid), 32'd1);
    check("ro_rsp_err", 32'(ro_err), 32'd1);
    check("ro_rsp_err_addr", ro_err_addr, 32'h40);
    check("ro_blocked_gnt", 32'(ro_gnt), 32'd0);
    check("ro_blocked_htrans", 32'(ro_htrans), 32'h0);
    next_cycle(); req = 1'b0; #1;
    check("ro_single_rvalid", 32'(ro_rvalid), 32'd0);
    next_cycle(); #1;
    next_cycle(); #1;

    // Reset during a waited write data phase.
    next_cycle(); req = 1'b1; we = 1'b1; addr = 32'h500; wdata = 32'h12345678; #1;
    check("rm_gnt", 32'(gnt), 32'd1);
    next_cycle(); req = 1'b0; we = 1'b0; hready = 1'b0; #1;
    check("rm_hwdata_before", hwdata, 32'h12345678);
    rstn_cpu = 1'b0; #1;
    check("rm_hwdata", hwdata, 32'd0);
    check("rm_htrans", 32'(htrans), 32'h0);
    check("rm_rvalid", 32'(rvalid), 32'd0);
    check("rm_gnt_rst", 32'(gnt), 32'd0);
    check("rm_err_addr", err_addr, 32'd0);
    next_cycle(); hready = 1'b1; #1;
    check("rm_in_rst_rvalid", 32'(rvalid), 32'd0);
    next_cycle(); rstn_cpu = 1'b1; #1;
    check("rm_rel0_rvalid", 32'(rvalid), 32'd0);
    next_cycle(); #1;
    check("rm_rel1_rvalid", 32'(rvalid), 32'd0);
    check("rm_rel1_hwdata", hwdata, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
